// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: sequential binary-search controller.
// Probes a hidden target through an external magnitude comparator (guess on
// the comparator's a input), narrows the [lo, hi] window from the one-hot
// greater/less/equal flags, and reports the match or "not found".
// The cmp_req/cmp_valid handshake tolerates both zero-wait (combinational)
// and multi-cycle (pipelined) comparators.
module sar_search_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4   // must hold WIDTH+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] guess,
  output logic             cmp_req,
  input  logic             cmp_valid,
  input  logic             cmp_g,
  input  logic             cmp_l,
  input  logic             cmp_e,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] steps,
  output logic             error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for start; results of last search held
    ST_WAIT = 2'd1,  // guess stable, waiting for comparator result
    ST_GAP  = 2'd2,  // one dead cycle after a new guess is loaded
    ST_DONE = 2'd3   // one-cycle done pulse
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Midpoint of two window bounds; the sum is formed one bit wider so that
  // (lo + hi) cannot wrap when both are near the top of the range.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] guess_q,  guess_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] steps_q,  steps_d;
  logic             found_q,  found_d;
  logic             error_q,  error_d;

  // Neighbouring window edges around the current guess. The guess == lo and
  // guess == hi exits below guarantee these are only used when they cannot
  // wrap.
  logic [WIDTH-1:0] guess_dec;
  logic [WIDTH-1:0] guess_inc;

  assign guess_dec = guess_q - ONE_W;
  assign guess_inc = guess_q + ONE_W;

  // State and datapath registers, cleared asynchronously.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      guess_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
      error_q  <= error_d;
    end
  end

  // Next-state, datapath update and state-decoded outputs.
  always_comb begin
    // NOTE: every signal gets a hold/idle default before the case statement,
    // so no path through the branches can leave one unassigned (no latches).
    state_d  = state_q;
    guess_d  = guess_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    result_d = result_q;
    steps_d  = steps_q;
    found_d  = found_q;
    error_d  = error_q;
    busy     = 1'b0;
    cmp_req  = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          lo_d    = '0;
          hi_d    = MAX_VAL;
          guess_d = midpoint('0, MAX_VAL);
          found_d = 1'b0;
          error_d = 1'b0;
          steps_d = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        busy    = 1'b1;
        cmp_req = 1'b1;
        if (cmp_valid) begin
          steps_d  = steps_q + ONE_C;
          result_d = guess_q;
          unique case ({cmp_g, cmp_l, cmp_e})
            3'b001: begin
              found_d = 1'b1;
              state_d = ST_DONE;
            end
            3'b100: begin
              // Target is below the guess: drop the upper half.
              if (guess_q == lo_q) begin
                state_d = ST_DONE;
              end else begin
                hi_d    = guess_dec;
                guess_d = midpoint(lo_q, guess_dec);
                state_d = ST_GAP;
              end
            end
            3'b010: begin
              // Target is above the guess: drop the lower half.
              if (guess_q == hi_q) begin
                state_d = ST_DONE;
              end else begin
                lo_d    = guess_inc;
                guess_d = midpoint(guess_inc, hi_q);
                state_d = ST_GAP;
              end
            end
            default: begin
              // Zero or multiple flags: comparator result is meaningless.
              error_d = 1'b1;
              found_d = 1'b0;
              state_d = ST_DONE;
            end
          endcase
        end
      end

      ST_GAP: begin
        // New guess is already on the bus; cmp_valid is ignored here so a
        // stale result from the previous probe cannot be consumed.
        busy    = 1'b1;
        state_d = ST_WAIT;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign steps  = steps_q;
  assign found  = found_q;
  assign error  = error_q;

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Sequential binary-search controller. It drives one side of the team's magnitude comparator and consumes the comparator's three result flags.
- It issues guesses against a hidden target, uses the greater / less / equal flags to halve the search window, and reports the matching value or "not found".
- A request/valid handshake on the comparator side means a combinational or a pipelined comparator can be attached.

Parameters:
- WIDTH, 4: width of guess, result and search range. Range is 0 to 2^WIDTH-1.
- CNT_W, 4: width of the steps counter. Must hold WIDTH+1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a search. Sampled only in IDLE.
- busy  out  1  high while a search is in progress (WAIT or GAP).
- guess  out  WIDTH  current probe value, driven to the comparator's a input.
- cmp_req  out  1  high while guess is stable and a result is awaited.
- cmp_valid  in  1  comparator result is valid this cycle.
- cmp_g  in  1  guess > target.
- cmp_l  in  1  guess < target.
- cmp_e  in  1  guess == target.
- done  out  1  one-cycle pulse at the end of a search.
- found  out  1  last search matched.
- result  out  WIDTH  last probed guess (the match when found=1).
- steps  out  CNT_W  number of comparisons consumed by the last search.
- error  out  1  last search aborted on invalid flags.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - guess, lo, hi, result, steps = 0.
  - busy, cmp_req, done, found, error = 0.
- States: IDLE, WAIT, GAP, DONE.
- IDLE:
  - On start=1: lo=0, hi=2^WIDTH-1, guess=(lo+hi)>>1; found, error, steps cleared. Next state WAIT.
  - On start=0: stay in IDLE; no output changes.
- WAIT:
  - cmp_req=1, busy=1. Stay until cmp_valid=1.
  - A cmp_valid arriving in the first WAIT cycle is accepted. This is the combinational-comparator case.
  - On the accepting cycle: steps increments and result = guess. Then decode the flags:
  - Flags not exactly one-hot: error=1, found=0, go to DONE.
  - cmp_e: found=1, go to DONE.
  - cmp_g:
    - If guess == lo: not found, go to DONE.
    - Otherwise: hi = guess-1, new guess = (lo + guess-1)>>1, go to GAP.
  - cmp_l:
    - If guess == hi: not found, go to DONE.
    - Otherwise: lo = guess+1, new guess = (guess+1 + hi)>>1, go to GAP.
- Arithmetic: compute midpoints in WIDTH+1 bits so the sum never overflows. The guess == lo / guess == hi checks mean lo and hi never underflow or overflow.
- GAP:
  - Exactly one cycle with cmp_req=0, busy=1, guess already updated. Next state WAIT.
  - cmp_valid during GAP is ignored.
- DONE:
  - done=1 for this one cycle; busy=0, cmp_req=0. Next state IDLE.
- Holding values:
  - found, result, steps and error hold until the next accepted start.
  - guess holds its last value in IDLE.
- start outside IDLE is ignored. start in DONE is ignored; it must be reasserted in IDLE.
- Maximum comparisons per search = WIDTH+1 (5 for WIDTH=4).
- Latency with a zero-wait comparator, start sampled at cycle T:
  - First result accepted at T+1.
  - Each further comparison adds 2 cycles.
  - done at T+2n, where n = steps.

Test Plan:
- Target 11, zero-wait comparator, start at T → guesses 7 (L), 11 (E); done at T+4; found=1, result=11, steps=2, error=0.
- Target 0 → guesses 7, 3, 1, 0 (G, G, G, E); found=1, result=0, steps=4.
- Target 15 → guesses 7, 11, 13, 14, 15; found=1, result=15, steps=5.
- Comparator stuck at G → guesses 7, 3, 1, 0, then G at guess==lo; done with found=0, result=0, steps=4. Stuck at L → ends at 15 with found=0, steps=5.
- Flags 3'b110 with cmp_valid on first probe → done with error=1, found=0, steps=1.
- Handshake and reset:
  - cmp_valid delayed 3 cycles per probe → cmp_req held, guess stable throughout; outcome identical to the zero-wait case.
  - start pulsed while busy → ignored.
  - rst asserted mid-WAIT → all outputs 0 immediately (asynchronous); a new start then behaves normally.
